vjtag_sysclk_cmd_queue: RTL and testbench

- System-clock side of the virtual-JTAG debug path, generalised from the fixed 2-bit-IR / 38-bit-DR sysclk decoder.
- Synchronises the TCK-domain update strobes (vs_udr, vs_uir) and captures the quasi-static ir_in/sr on each update-DR.
- Queues captured commands in a DEPTH-entry FIFO and presents them to the debug core over valid/ready, with a one-hot IR decode and an action/no-action flag.
- Adds back-pressure, overflow detection and drop counting, which the single-register predecessor lacks.

---
 rtl/vjtag_sysclk_cmd_queue.sv | 153 +++++++++++++++
 tb/tb_vjtag_sysclk_cmd_queue.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vjtag_sysclk_cmd_queue.sv
// System-clock side of the virtual-JTAG debug path: synchronises TCK-domain update
// strobes, captures ir_in/sr on each update-DR and queues them for the debug core.
module vjtag_sysclk_cmd_queue #(
    parameter int IR_W        = 2,
    parameter int DR_W        = 38,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4,
    parameter int ACTION_BIT  = 35,
    parameter int DROP_W      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     vs_udr,
    input  logic                     vs_uir,
    input  logic [IR_W-1:0]          ir_in,
    input  logic [DR_W-1:0]          sr,
    input  logic                     cmd_ready,
    input  logic                     clear_overflow,
    output logic                     cmd_valid,
    output logic [IR_W-1:0]          cmd_ir,
    output logic [DR_W-1:0]          cmd_data,
    output logic                     cmd_action,
    output logic [(2**IR_W)-1:0]     cmd_sel,
    output logic [DR_W-1:0]          jdo,
    output logic                     ir_update,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int SEL_W = 2**IR_W;

    // Synchronisers and edge history reset to 1 so a strobe already high at
    // reset release is not mistaken for a fresh rising edge.
    logic [SYNC_STAGES-1:0] udr_sync;
    logic [SYNC_STAGES-1:0] uir_sync;
    logic                   udr_hist;
    logic                   uir_hist;
    logic                   udr_edge;
    logic                   uir_edge;

    always_ff @(posedge clk) begin
        if (reset) begin
            udr_sync <= '1;
            uir_sync <= '1;
            udr_hist <= 1'b1;
            uir_hist <= 1'b1;
        end else begin
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_hist <= udr_sync[SYNC_STAGES-1];
            uir_hist <= uir_sync[SYNC_STAGES-1];
        end
    end

    assign udr_edge = udr_sync[SYNC_STAGES-1] & ~udr_hist;
    assign uir_edge = uir_sync[SYNC_STAGES-1] & ~uir_hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_update <= 1'b0;
        end else begin
            ir_update <= uir_edge;
        end
    end

    // jdo mirrors every capture, including ones the queue had to drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            jdo <= '0;
        end else if (udr_edge) begin
            jdo <= sr;
        end
    end

    // Handshake: a transfer happens on a clock edge where cmd_valid && cmd_ready;
    // cmd_valid and the head fields stay stable until that transfer, and
    // cmd_ready has no effect while the queue is empty.
    logic [IR_W-1:0] mem_ir   [DEPTH];
    logic [DR_W-1:0] mem_data [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            full;
    logic            pop;
    logic            push_ok;
    logic            drop;

    assign full      = (fifo_level == LW'(DEPTH));
    assign cmd_valid = (fifo_level != '0);
    assign pop       = cmd_valid & cmd_ready;
    // A full queue still takes the capture when the head leaves in the same cycle.
    assign push_ok   = udr_edge & (~full | pop);
    assign drop      = udr_edge & full & ~pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_ir[wr_ptr]   <= ir_in;
            mem_data[wr_ptr] <= sr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // A drop in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear_overflow) begin
            overflow   <= drop;
            drop_count <= drop ? DROP_W'(1) : '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) begin
                drop_count <= drop_count + DROP_W'(1);
            end
        end
    end

    assign cmd_ir     = cmd_valid ? mem_ir[rd_ptr] : '0;
    assign cmd_data   = cmd_valid ? mem_data[rd_ptr] : '0;
    assign cmd_action = cmd_data[ACTION_BIT];

    always_comb begin
        cmd_sel = '0;
        for (int i = 0; i < SEL_W; i++) begin
            if (cmd_valid && (cmd_ir == IR_W'(i))) begin
                cmd_sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vjtag_sysclk_cmd_queue.sv
// Randomised scoreboard bench for vjtag_sysclk_cmd_queue: a queue-based reference
// model predicts accepted captures, drops and strobe pulses cycle by cycle.
module tb_vjtag_sysclk_cmd_queue;

    localparam int IR_W        = 2;
    localparam int DR_W        = 38;
    localparam int SYNC_STAGES = 2;
    localparam int DEPTH       = 4;
    localparam int ACTION_BIT  = 35;
    localparam int DROP_W      = 8;
    localparam int SEL_W       = 2**IR_W;
    localparam int LW          = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset = 1'b1;
    logic              vs_udr = 1'b0;
    logic              vs_uir = 1'b0;
    logic [IR_W-1:0]   ir_in = '0;
    logic [DR_W-1:0]   sr = '0;
    logic              cmd_ready = 1'b0;
    logic              clear_overflow = 1'b0;
    logic              cmd_valid;
    logic [IR_W-1:0]   cmd_ir;
    logic [DR_W-1:0]   cmd_data;
    logic              cmd_action;
    logic [SEL_W-1:0]  cmd_sel;
    logic [DR_W-1:0]   jdo;
    logic              ir_update;
    logic [LW-1:0]     fifo_level;
    logic              overflow;
    logic [DROP_W-1:0] drop_count;

    vjtag_sysclk_cmd_queue #(
        .IR_W(IR_W), .DR_W(DR_W), .SYNC_STAGES(SYNC_STAGES),
        .DEPTH(DEPTH), .ACTION_BIT(ACTION_BIT), .DROP_W(DROP_W)
    ) dut (
        .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir),
        .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready),
        .clear_overflow(clear_overflow), .cmd_valid(cmd_valid),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .cmd_action(cmd_action),
        .cmd_sel(cmd_sel), .jdo(jdo), .ir_update(ir_update),
        .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count)
    );

    // ---------------- scoreboard state ----------------
    typedef struct {
        int              due;
        logic [IR_W-1:0] ir;
        logic [DR_W-1:0] data;
    } cap_t;

    cap_t                   pend[$];
    logic [IR_W+DR_W-1:0]   exp_q[$];
    int                     compared = 0;
    int                     mismatched = 0;
    int                     cyc = 0;
    int                     m_level = 0;
    bit                     m_ovf = 0;
    int                     m_drops = 0;
    logic [DR_W-1:0]        m_jdo = '0;
    int                     uir_due = -100;
    int                     last_push = -100;
    int                     uir_pulses = 0;
    int                     rdy_mode = 0;
    int                     clr_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: abstract queue + counters, evaluated at each clock edge.
    initial begin
        bit   pop_m;
        bit   push_m;
        bit   drop_m;
        cap_t cap;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                exp_q.delete();
                pend.delete();
                m_level = 0;
                m_ovf   = 0;
                m_drops = 0;
                m_jdo   = '0;
            end else begin
                pop_m  = (m_level > 0) && cmd_ready;
                push_m = 0;
                drop_m = 0;
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    cap   = pend.pop_front();
                    m_jdo = cap.data;
                    if (m_level < DEPTH || pop_m) push_m = 1;
                    else drop_m = 1;
                end
                if (pop_m) m_level--;
                if (push_m) begin
                    m_level++;
                    exp_q.push_back({cap.ir, cap.data});
                end
                if (clear_overflow) begin
                    m_ovf   = drop_m;
                    m_drops = drop_m ? 1 : 0;
                end else if (drop_m) begin
                    m_ovf = 1;
                    if (m_drops < 2**DROP_W - 1) m_drops++;
                end
            end
        end
    end

    // Monitor: compares every cycle, pops the expected queue on each transfer.
    initial begin
        logic [IR_W+DR_W-1:0] e;
        logic [SEL_W-1:0]     es;
        forever begin
            @(negedge clk);
            chk("level", 64'(fifo_level), 64'(m_level));
            chk("valid", 64'(cmd_valid), 64'(m_level > 0));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("drop_count", 64'(drop_count), 64'(m_drops));
            chk("jdo", 64'(jdo), 64'(m_jdo));
            chk("ir_update", 64'(ir_update), 64'(cyc == uir_due));
            if (ir_update) uir_pulses++;
            if (m_level > 0 && exp_q.size() > 0) begin
                e  = exp_q[0];
                es = '0;
                es[e[IR_W+DR_W-1:DR_W]] = 1'b1;
                chk("head_ir", 64'(cmd_ir), 64'(e[IR_W+DR_W-1:DR_W]));
                chk("head_data", 64'(cmd_data), 64'(e[DR_W-1:0]));
                chk("head_action", 64'(cmd_action), 64'(e[ACTION_BIT]));
                chk("head_sel", 64'(cmd_sel), 64'(es));
            end else begin
                chk("idle_sel", 64'(cmd_sel), 64'd0);
                chk("idle_data", 64'(cmd_data), 64'd0);
            end
            if (cmd_valid && cmd_ready) begin
                if (exp_q.size() == 0) chk("pop_unexpected", 64'(cmd_valid), 64'd0);
                else void'(exp_q.pop_front());
            end
        end
    end

    // Background drivers for cmd_ready / clear_overflow.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) cmd_ready = 1'($urandom_range(0, 1));
            else if (rdy_mode == 2) cmd_ready = (cyc + 1 == last_push);
            if (clr_mode == 2) clear_overflow = (cyc + 1 == last_push);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] d);
        step(1);
        ir_in  = ir;
        sr     = d;
        vs_udr = 1'b1;
        last_push = cyc + 1 + SYNC_STAGES;
        pend.push_back('{cyc + 1 + SYNC_STAGES, ir, d});
        step(SYNC_STAGES + 2);
        vs_udr = 1'b0;
        step(SYNC_STAGES + 1);
    endtask

    task automatic uir_pulse();
        step(1);
        vs_uir  = 1'b1;
        uir_due = cyc + 1 + SYNC_STAGES;
        step(SYNC_STAGES + 2);
        vs_uir = 1'b0;
        step(SYNC_STAGES + 1);
    endtask

    function automatic logic [DR_W-1:0] rand_dr();
        return DR_W'({$urandom(), $urandom()});
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int p0;
        step(3);
        reset = 1'b0;
        step(2);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_jdo", 64'(jdo), 64'd0);

        // Single capture, head presented while cmd_ready stays low.
        capture(2'd2, 38'h20_0000_1234);
        chk("t1_valid", 64'(cmd_valid), 64'd1);
        chk("t1_ir", 64'(cmd_ir), 64'd2);
        chk("t1_sel", 64'(cmd_sel), 64'b0100);
        chk("t1_data", 64'(cmd_data), 64'h20_0000_1234);
        chk("t1_jdo", 64'(jdo), 64'h20_0000_1234);
        chk("t1_level", 64'(fifo_level), 64'd1);
        cmd_ready = 1'b1;
        step(2);
        cmd_ready = 1'b0;

        // Five captures into a four-entry queue, then drain.
        for (int i = 1; i <= 5; i++) capture(IR_W'($urandom_range(0, SEL_W - 1)), DR_W'(i));
        chk("t2_level", 64'(fifo_level), 64'd4);
        chk("t2_overflow", 64'(overflow), 64'd1);
        chk("t2_drops", 64'(drop_count), 64'd1);
        chk("t2_jdo", 64'(jdo), 64'd5);
        cmd_ready = 1'b1;
        step(6);
        cmd_ready = 1'b0;
        chk("t2_drained", 64'(cmd_valid), 64'd0);
        clear_overflow = 1'b1;
        step(1);
        clear_overflow = 1'b0;
        step(1);

        // Full queue, capture coinciding with a pop.
        for (int i = 0; i < DEPTH; i++) capture(IR_W'(i), rand_dr());
        rdy_mode = 2;
        capture(2'd3, rand_dr());
        rdy_mode  = 0;
        cmd_ready = 1'b0;
        chk("t3_level", 64'(fifo_level), 64'd4);
        chk("t3_overflow", 64'(overflow), 64'd0);

        // Saturating drop counter and clear/drop collision.
        repeat (300) capture(IR_W'($urandom_range(0, SEL_W - 1)), rand_dr());
        chk("t4_sat", 64'(drop_count), 64'd255);
        clr_mode = 2;
        capture(2'd1, rand_dr());
        clr_mode = 0;
        clear_overflow = 1'b0;
        chk("t4_collide_ovf", 64'(overflow), 64'd1);
        chk("t4_collide_cnt", 64'(drop_count), 64'd1);
        clear_overflow = 1'b1;
        step(1);
        clear_overflow = 1'b0;
        step(1);
        chk("t4_clear_ovf", 64'(overflow), 64'd0);
        chk("t4_clear_cnt", 64'(drop_count), 64'd0);

        // Strobe held high across reset release gives no capture.
        reset  = 1'b1;
        vs_udr = 1'b1;
        step(3);
        reset = 1'b0;
        step(6);
        chk("t5_no_push", 64'(cmd_valid), 64'd0);
        vs_udr = 1'b0;
        step(4);
        for (int i = 0; i < 3; i++) capture(IR_W'(i), rand_dr());
        chk("t5_level3", 64'(fifo_level), 64'd3);
        reset = 1'b1;
        step(1);
        chk("t5_rst_level", 64'(fifo_level), 64'd0);
        chk("t5_rst_valid", 64'(cmd_valid), 64'd0);
        reset = 1'b0;
        step(2);

        // Update-IR pulse.
        p0 = uir_pulses;
        uir_pulse();
        chk("t6_pulses", 64'(uir_pulses - p0), 64'd1);
        chk("t6_level", 64'(fifo_level), 64'd0);

        // Random traffic with random back-pressure.
        rdy_mode = 1;
        repeat (150) begin
            if ($urandom_range(0, 9) == 0) begin
                step(1);
                clear_overflow = 1'b1;
                step(1);
                clear_overflow = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) begin
                fork
                    capture(IR_W'($urandom_range(0, SEL_W - 1)), rand_dr());
                    uir_pulse();
                join
            end else begin
                capture(IR_W'($urandom_range(0, SEL_W - 1)), rand_dr());
            end
        end
        rdy_mode  = 0;
        cmd_ready = 1'b1;
        step(DEPTH + 4);
        chk("final_empty", 64'(cmd_valid), 64'd0);
        chk("final_queue", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
